// File: rtl/led_pattern_ctrl_if.sv
// Command port of the LED pattern sequencer: the host drives a mode plus the
// timing fields, and the sequencer answers with cmd_ready.
interface led_pattern_ctrl_if #(
  parameter int HP_W  = 16,
  parameter int CNT_W = 8
);
  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high. Fields are sampled only on that edge; while
  // cmd_ready is low, cmd_valid is ignored and nothing is queued.
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [HP_W-1:0]  cmd_half_period;
  logic [CNT_W-1:0] cmd_count;

  modport master (
    output cmd_valid, cmd_mode, cmd_half_period, cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_half_period, cmd_count,
    output cmd_ready
  );
endinterface

// File: rtl/led_pattern_ctrl.sv
// Command-driven LED sequencer: steady OFF/ON levels, continuous BLINK and
// counted BURST patterns, all timed in prescaler ticks.
module led_pattern_ctrl #(
  parameter int PRESCALE = 25000,
  parameter int HP_W     = 16,
  parameter int CNT_W    = 8
) (
  input  logic                     clk_25mhz,
  input  logic                     rst,
  led_pattern_ctrl_if.slave        cmd,
  output logic                     led,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               state_dbg
);

  localparam int PRE_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ON_PH  = 2'd1,
    OFF_PH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [HP_W-1:0]  ph_q, ph_d, h_q, h_d, h_eff;
  logic [CNT_W-1:0] pulse_q, pulse_d, n_q, n_d, pulse_inc;
  logic             burst_q, burst_d;
  logic             base_q, base_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             accept, tick, ph_last;

  assign accept    = cmd.cmd_valid & ready_q;
  assign tick      = (pre_q == PRE_LAST);
  // A half-period of zero runs as one tick so a phase can never be empty.
  assign h_eff     = (h_q == '0) ? HP_W'(1) : h_q;
  assign ph_last   = (ph_q == h_eff - HP_W'(1));
  assign pulse_inc = pulse_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    pre_d   = tick ? '0 : pre_q + PRE_W'(1);
    ph_d    = ph_q;
    h_d     = h_q;
    pulse_d = pulse_q;
    n_d     = n_q;
    burst_d = burst_q;
    base_d  = base_q;
    led_d   = led_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = ready_q;

    if (accept) begin
      // Restarting the prescaler on accept makes the first phase exact.
      pre_d   = '0;
      ph_d    = '0;
      pulse_d = '0;
      state_d = IDLE;
      busy_d  = 1'b0;
      ready_d = 1'b1;
      case (cmd.cmd_mode)
        MODE_OFF: begin
          base_d = 1'b0;
          led_d  = 1'b0;
        end
        MODE_ON: begin
          base_d = 1'b1;
          led_d  = 1'b1;
        end
        MODE_BLINK: begin
          h_d     = cmd.cmd_half_period;
          burst_d = 1'b0;
          led_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = ON_PH;
        end
        default: begin
          if (cmd.cmd_count == '0) begin
            led_d  = base_q;
            done_d = 1'b1;
          end else begin
            h_d     = cmd.cmd_half_period;
            n_d     = cmd.cmd_count;
            burst_d = 1'b1;
            led_d   = 1'b1;
            busy_d  = 1'b1;
            ready_d = 1'b0;
            state_d = ON_PH;
          end
        end
      endcase
    end else begin
      case (state_q)
        ON_PH: begin
          if (tick) begin
            if (ph_last) begin
              ph_d    = '0;
              led_d   = 1'b0;
              state_d = OFF_PH;
            end else begin
              ph_d = ph_q + HP_W'(1);
            end
          end
        end
        OFF_PH: begin
          if (tick) begin
            if (ph_last) begin
              ph_d = '0;
              if (burst_q && (pulse_inc == n_q)) begin
                pulse_d = pulse_inc;
                led_d   = base_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                ready_d = 1'b1;
                state_d = IDLE;
              end else begin
                if (burst_q) pulse_d = pulse_inc;
                led_d   = 1'b1;
                state_d = ON_PH;
              end
            end else begin
              ph_d = ph_q + HP_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      ph_q    <= '0;
      h_q     <= '0;
      pulse_q <= '0;
      n_q     <= '0;
      burst_q <= 1'b0;
      base_q  <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      ph_q    <= ph_d;
      h_q     <= h_d;
      pulse_q <= pulse_d;
      n_q     <= n_d;
      burst_q <= burst_d;
      base_q  <= base_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign led           = led_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cmd.cmd_ready = ready_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with PRESCALE=4: each scenario queues the
// expected {led,busy,cmd_ready,done} per cycle and drains it against the DUT.
module tb_led_pattern_ctrl;

  localparam int PRESCALE = 4;
  localparam int HP_W     = 8;
  localparam int CNT_W    = 4;

  logic       clk_25mhz = 1'b0;
  logic       rst;
  logic       led, busy, done;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  led_pattern_ctrl_if #(.HP_W(HP_W), .CNT_W(CNT_W)) bus ();

  led_pattern_ctrl #(.PRESCALE(PRESCALE), .HP_W(HP_W), .CNT_W(CNT_W)) dut (
    .clk_25mhz (clk_25mhz),
    .rst       (rst),
    .cmd       (bus.slave),
    .led       (led),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk_25mhz = ~clk_25mhz;

  function automatic logic [3:0] outs();
    return {led, busy, bus.cmd_ready, done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks: all sampling happens 1 time unit after a rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_25mhz);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] mode, input logic [HP_W-1:0] hp, input logic [CNT_W-1:0] cnt);
    bus.cmd_valid       = 1'b1;
    bus.cmd_mode        = mode;
    bus.cmd_half_period = hp;
    bus.cmd_count       = cnt;
    step(1);
    bus.cmd_valid       = 1'b0;
  endtask

  task automatic run_q(input string tag);
    while (exp_q.size() > 0) begin
      check(tag, 32'(outs()), 32'(exp_q.pop_front()));
      step(1);
    end
  endtask

  initial begin
    int seen_done;
    int seen_led;
    rst                 = 1'b1;
    bus.cmd_valid       = 1'b0;
    bus.cmd_mode        = 2'd0;
    bus.cmd_half_period = '0;
    bus.cmd_count       = '0;

    step(2);
    check("reset_outs", 32'(outs()), 32'b0010);
    check("reset_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    step(1);
    check("idle_outs", 32'(outs()), 32'b0010);

    // ON, then BLINK H=2 (8 on / 8 off), then OFF mid on-phase
    send(2'd1, 8'd0, 4'd0);
    check("on_outs", 32'(outs()), 32'b1010);
    step(2);
    check("on_hold", 32'(outs()), 32'b1010);
    send(2'd2, 8'd2, 4'd0);
    for (int k = 0; k < 20; k++)
      exp_q.push_back({(((k / 8) % 2) == 0) ? 1'b1 : 1'b0, 3'b110});
    run_q("blink_h2");
    send(2'd0, 8'd0, 4'd0);
    check("blink_off_outs", 32'(outs()), 32'b0010);
    check("blink_off_state", 32'(state_dbg), 32'd0);

    // BURST H=1 N=3 on base 0: three 4-clock pulses, done 24 clocks after accept
    send(2'd3, 8'd1, 4'd3);
    for (int k = 0; k < 24; k++)
      exp_q.push_back({(((k / 4) % 2) == 0) ? 1'b1 : 1'b0, 3'b100});
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0010);
    run_q("burst_h1_n3");

    // BURST N=0 with base 1: led untouched, done one cycle after accept
    send(2'd1, 8'd0, 4'd0);
    check("on_again", 32'(outs()), 32'b1010);
    send(2'd3, 8'd5, 4'd0);
    check("burst_n0_done", 32'(outs()), 32'b1011);
    check("burst_n0_state", 32'(state_dbg), 32'd0);
    step(1);
    check("burst_n0_after", 32'(outs()), 32'b1010);

    // ON held on the bus during a BURST: ignored until the done cycle
    send(2'd0, 8'd0, 4'd0);
    send(2'd3, 8'd1, 4'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = 2'd1;
    bus.cmd_half_period = 8'd9;
    bus.cmd_count = 4'd7;
    for (int k = 0; k < 4; k++) exp_q.push_back(4'b1100);
    for (int k = 0; k < 4; k++) exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0011);
    run_q("burst_held_on");
    bus.cmd_valid = 1'b0;
    check("held_on_accepted", 32'(outs()), 32'b1010);

    // BLINK H=0 runs as H=1; re-issue in the off-phase restarts a full on-phase
    send(2'd2, 8'd0, 4'd0);
    for (int k = 0; k < 4; k++) exp_q.push_back(4'b1110);
    exp_q.push_back(4'b0110);
    run_q("blink_h0");
    check("blink_h0_offph", 32'(state_dbg), 32'd2);
    send(2'd2, 8'd0, 4'd0);
    for (int k = 0; k < 4; k++) exp_q.push_back(4'b1110);
    exp_q.push_back(4'b0110);
    run_q("blink_reissue");
    send(2'd0, 8'd0, 4'd0);
    check("blink_h0_off", 32'(outs()), 32'b0010);

    // asynchronous reset in the middle of a BURST on-phase
    send(2'd3, 8'd2, 4'd5);
    step(3);
    check("pre_rst_state", 32'(state_dbg), 32'd1);
    check("pre_rst_outs", 32'(outs()), 32'b1100);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outs", 32'(outs()), 32'b0010);
    check("async_rst_state", 32'(state_dbg), 32'd0);
    step(2);
    rst = 1'b0;
    seen_done = 0;
    seen_led  = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) seen_done++;
      if (led)  seen_led++;
      step(1);
    end
    check("rst_no_done", 32'(seen_done), 32'd0);
    check("rst_led_low", 32'(seen_led), 32'd0);
    check("rst_final", 32'(outs()), 32'b0010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
